run_sequencer: RTL and testbench
================================

# run_sequencer

Host-side initiator for the processor core's `req`/`done` handshake. On a host `start`, it executes a sequence of NRUNS program runs. For each run it holds the core in reset, issues a one-cycle `req`, waits for `done`, and counts the execution cycles. It sits outside `top_level`, drives the core's `reset` and `req`, and reports a per-run cycle count plus overall completion or timeout to the host or bench.

## Interface
- NRUNS, 3: number of core runs per `start`; 1..2^RW.
- RW, 2: width of `run_idx`; 2^RW ≥ NRUNS.
- CW, 16: cycle counter width.
- RST_CYC, 2: cycles `core_reset` is held in CRST; ≥1.
- TMO, 4096: RUN-cycle limit before timeout; used only with TIMEOUT_EN; TMO ≤ 2^CW-1.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  host request; sampled only in IDLE, FINISH or TOUT.
- core_done  in  1  core `done`; observed only in RUN.
- core_reset  out  1  drives the core's `reset`.
- core_req  out  1  drives the core's `req`.
- busy  out  1  high in CRST, REQ, RUN and REPORT.
- run_idx  out  RW  index of the current or last run.
- cycles  out  CW  cycle count latched for the last completed run.
- result_valid  out  1  one-cycle pulse when `cycles` updates.
- all_done  out  1  sequence completed; held until the next accepted `start` or `reset`.
- timed_out  out  1  run aborted on timeout; held until the next accepted `start` or `reset`.

## Operation
- States: IDLE, CRST, REQ, RUN, REPORT, FINISH, TOUT. Every output is registered or decoded from the state register only, with no combinational path from inputs.
- Reset state is IDLE. Reset values: `core_reset`=1; `core_req`, `busy`, `result_valid`, `all_done`, `timed_out`=0; `run_idx`=0; `cycles`=0.
- `core_reset`=1 in IDLE, CRST, FINISH and TOUT; 0 in REQ, RUN and REPORT. The core is parked in reset whenever the sequencer is idle.
- `core_req`=1 only in REQ.
- IDLE/FINISH/TOUT with `start`=1: go to CRST, set `run_idx`=0, clear `all_done` and `timed_out`, reload the reset counter.
- CRST: stay exactly RST_CYC cycles, then go to REQ.
- REQ: lasts one cycle. Clear the cycle counter. Go to RUN.
- RUN, `core_done`=0: counter increments and saturates at 2^CW-1.
- RUN, `core_done`=1: latch the counter into `cycles`, go to REPORT. If `done` is high in the first RUN cycle, `cycles`=0.
- REPORT: `result_valid`=1 for this cycle.
  - If `run_idx`==NRUNS-1, go to FINISH and set `all_done`.
  - Otherwise increment `run_idx` and go to CRST.
- `start` is ignored while `busy`=1.
- `core_done` outside RUN is ignored. It stays high after a run until the core is reset, which is why CRST precedes every run.
- Reset asserted in any state, mid-run included: next edge gives IDLE with all reset values; the run in progress is abandoned and no `result_valid` is issued.

## Timing
- `start` sampled high at edge k: CRST from k+1 to k+RST_CYC; REQ at k+RST_CYC+1; RUN from k+RST_CYC+2.
- `core_done` sampled high at RUN edge m: REPORT, `result_valid` and the new `cycles` are visible after edge m.
- The next run's CRST begins after edge m+1.
- Per-run overhead outside RUN is RST_CYC+2 cycles (CRST, REQ, REPORT).
- `cycles` equals the number of RUN cycles sampled with `core_done`=0.

## Configuration
- `RUN_SEQUENCER_TIMEOUT_EN` defined:
  - In RUN, if the counter equals TMO-1 and `core_done`=0, go to TOUT, set `timed_out`=1, and leave `cycles` unchanged with no `result_valid`.
  - TOUT holds `core_reset`=1 and `busy`=0 until `start`.
  - If `core_done` and the TMO-1 condition occur in the same cycle, `done` wins (REPORT).
- Not defined: TOUT is unreachable, `timed_out` is constant 0, and RUN waits for `core_done` indefinitely.

## Test plan
- Reset, then idle 5 cycles: `core_reset`=1, `core_req`=0, `busy`=0, `cycles`=0, and no flags set.
- NRUNS=3, RST_CYC=2; model the core raising `done` after 10, 0 and 37 RUN cycles:
  - three `result_valid` pulses with `cycles`=10, 0, 37 and `run_idx`=0, 1, 2;
  - `core_req` pulses exactly 3 times, each one cycle wide;
  - `all_done`=1 after the third REPORT.
- `start` pulsed during RUN of run 1: ignored; the sequence completes unchanged. A `start` in FINISH clears `all_done` and restarts at `run_idx`=0.
- `core_done` held high through CRST and REQ: no REPORT until RUN. Held high at RUN entry: `cycles`=0.
- TIMEOUT_EN with TMO=16 and the core never raising `done`: TOUT after 16 RUN cycles, `timed_out`=1, `core_reset`=1, no `result_valid`. Variant with `done` on the 16th RUN cycle: REPORT with `cycles`=15 and no timeout.
- `reset` asserted at RUN cycle 5 of run 1: IDLE next edge, `run_idx`=0, `cycles`=0, no pulse. A subsequent `start` runs the full sequence correctly.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: host-side initiator for a core's req/done handshake.
// On an accepted start it performs NRUNS runs. Each run holds the core in reset for
// RST_CYC cycles, pulses req for one cycle, then counts RUN cycles until done.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   start        host request, accepted only in IDLE, FINISH or TOUT
//   core_done    core completion, observed only in RUN
//   core_reset   drives the core's reset (high whenever not running)
//   core_req     one-cycle request to the core
//   busy         high in CRST, REQ, RUN and REPORT
//   run_idx      index of the current or last run
//   cycles       RUN cycle count latched for the last completed run
//   result_valid one-cycle pulse when cycles updates
//   all_done     sequence completed, held until next start or reset
//   timed_out    run aborted on timeout, held until next start or reset
//
// Optional feature: define RUN_SEQUENCER_TIMEOUT_EN to abort a run after TMO RUN cycles.
// Without it, timed_out stays 0 and RUN waits for core_done indefinitely.

module run_sequencer #(
    parameter int unsigned NRUNS   = 3,
    parameter int unsigned RW      = 2,
    parameter int unsigned CW      = 16,
    parameter int unsigned RST_CYC = 2,
    parameter int unsigned TMO     = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_req,
    output logic          busy,
    output logic [RW-1:0] run_idx,
    output logic [CW-1:0] cycles,
    output logic          result_valid,
    output logic          all_done,
    output logic          timed_out
);

    typedef enum logic [2:0] {
        StIdle, StCrst, StReq, StRun, StReport, StFinish, StTout
    } state_e;

    localparam logic [RW-1:0] LastIdx = RW'(NRUNS - 1);
    localparam logic [CW-1:0] TmoLast = CW'(TMO - 1);
    localparam logic [31:0]   RstLoad = 32'(RST_CYC - 1);

`ifdef RUN_SEQUENCER_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    state_e        state;
    logic [CW-1:0] cnt;
    logic [31:0]   rst_cnt;
    logic          tmo_hit;

    // Constant-false when the timeout feature is compiled out, so TOUT is unreachable.
    assign tmo_hit = TmoEn && (cnt == TmoLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            cnt          <= '0;
            rst_cnt      <= '0;
            run_idx      <= '0;
            cycles       <= '0;
            result_valid <= 1'b0;
            all_done     <= 1'b0;
            timed_out    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                StIdle, StFinish, StTout: begin
                    if (start) begin
                        state     <= StCrst;
                        run_idx   <= '0;
                        all_done  <= 1'b0;
                        timed_out <= 1'b0;
                        rst_cnt   <= RstLoad;
                    end
                end
                StCrst: begin
                    if (rst_cnt == '0) begin
                        state <= StReq;
                    end else begin
                        rst_cnt <= rst_cnt - 32'd1;
                    end
                end
                StReq: begin
                    cnt   <= '0;
                    state <= StRun;
                end
                StRun: begin
                    // done takes priority over a coincident timeout
                    if (core_done) begin
                        cycles       <= cnt;
                        result_valid <= 1'b1;
                        state        <= StReport;
                    end else if (tmo_hit) begin
                        timed_out <= 1'b1;
                        state     <= StTout;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StReport: begin
                    if (run_idx == LastIdx) begin
                        all_done <= 1'b1;
                        state    <= StFinish;
                    end else begin
                        run_idx <= run_idx + 1'b1;
                        rst_cnt <= RstLoad;
                        state   <= StCrst;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Decoded from the state register only; no input-to-output paths.
    assign core_reset = (state == StIdle) || (state == StCrst) ||
                        (state == StFinish) || (state == StTout);
    assign core_req   = (state == StReq);
    assign busy       = (state == StCrst) || (state == StReq) ||
                        (state == StRun) || (state == StReport);

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: behavioural core model, result scoreboard,
// table of run sequences plus hand-written reset/done-held/timeout sequences.

module tb_run_sequencer;

    localparam int NRUNS   = 3;
    localparam int RW      = 2;
    localparam int CW      = 16;
    localparam int RST_CYC = 2;
    localparam int TMO     = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic          core_done;
    logic          core_reset;
    logic          core_req;
    logic          busy;
    logic [RW-1:0] run_idx;
    logic [CW-1:0] cycles;
    logic          result_valid;
    logic          all_done;
    logic          timed_out;

    run_sequencer #(
        .NRUNS   (NRUNS),
        .RW      (RW),
        .CW      (CW),
        .RST_CYC (RST_CYC),
        .TMO     (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .core_done    (core_done),
        .core_reset   (core_reset),
        .core_req     (core_req),
        .busy         (busy),
        .run_idx      (run_idx),
        .cycles       (cycles),
        .result_valid (result_valid),
        .all_done     (all_done),
        .timed_out    (timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- core model ----------------
    // Raises done after 'lat' RUN cycles sampled low; done stays high until core reset.
    int  lat_q[$];
    bit  model_done = 1'b0;
    bit  force_done = 1'b0;
    bit  running    = 1'b0;
    int  left       = 0;
    logic in_run;

    assign core_done = model_done | force_done;
    assign in_run    = busy & ~core_reset & ~core_req & ~result_valid;

    always @(negedge clk) begin
        if (core_reset) begin
            model_done = 1'b0;
            running    = 1'b0;
        end else if (core_req) begin
            left       = (lat_q.size() > 0) ? lat_q.pop_front() : 100000;
            model_done = 1'b0;
            running    = 1'b1;
        end else if (running) begin
            if (left == 0) begin
                model_done = 1'b1;
                running    = 1'b0;
            end else begin
                left--;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        int idx;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   req_count = 0;
    bit   req_prev  = 1'b0;
    int   run_cyc   = 0;

    always @(negedge clk) begin
        if (result_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_cycles", cycles, e.cyc);
                check("result_run_idx", run_idx, e.idx);
            end
        end
        if (core_req) begin
            req_count++;
            if (req_prev) check("core_req_width", 2, 1);
        end
        req_prev = core_req;
        if (in_run) run_cyc++;
    end

    // ---------------- helpers ----------------
    task automatic wait_run(input int idx);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (run_idx == RW'(idx) && in_run) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_run_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (all_done || timed_out) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_end_timeout", 0, 1);
    endtask

    task automatic run_seq(input int l0, input int l1, input int l2,
                           input int e0, input int e1, input int e2, input bit poke);
        exp_t e;
        int   rq0;
        lat_q.push_back(l0);
        lat_q.push_back(l1);
        lat_q.push_back(l2);
        e.idx = 0; e.cyc = e0; sb.push_back(e);
        e.idx = 1; e.cyc = e1; sb.push_back(e);
        e.idx = 2; e.cyc = e2; sb.push_back(e);
        rq0 = req_count;
        pulse_start();
        // first CRST cycle
        check("start_busy", busy, 1);
        check("start_core_reset", core_reset, 1);
        check("start_run_idx", run_idx, 0);
        check("start_all_done_clr", all_done, 0);
        check("start_timed_out_clr", timed_out, 0);
        for (int i = 0; i < RST_CYC; i++) begin
            @(negedge clk);
            check("no_early_result", result_valid, 0);
        end
        check("req_after_crst", core_req, 1);
        if (poke) begin
            wait_run(1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_end();
        check("end_all_done", all_done, 1);
        check("end_timed_out", timed_out, 0);
        check("end_req_pulses", req_count - rq0, 3);
        check("end_sb_empty", sb.size(), 0);
        check("end_busy", busy, 0);
        check("end_core_reset", core_reset, 1);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int lat0, lat1, lat2;
        int exp0, exp1, exp2;
        bit poke;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{10, 0, 37, 10, 0, 37, 1'b0};
        vecs[1] = '{1, 2, 3, 1, 2, 3, 1'b0};
        vecs[2] = '{4, 20, 6, 4, 20, 6, 1'b1};
        vecs[3] = '{0, 0, 0, 0, 0, 0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_core_reset", core_reset, 1);
        check("idle_core_req", core_req, 0);
        check("idle_busy", busy, 0);
        check("idle_cycles", cycles, 0);
        check("idle_result_valid", result_valid, 0);
        check("idle_all_done", all_done, 0);
        check("idle_timed_out", timed_out, 0);
        check("idle_run_idx", run_idx, 0);

        // Back-to-back sequences: each later start is accepted from FINISH.
        for (int v = 0; v < 4; v++) begin
            run_seq(vecs[v].lat0, vecs[v].lat1, vecs[v].lat2,
                    vecs[v].exp0, vecs[v].exp1, vecs[v].exp2, vecs[v].poke);
        end

        // done held high through CRST and REQ: every run reports zero cycles.
        force_done = 1'b1;
        run_seq(5, 5, 5, 0, 0, 0, 1'b0);
        force_done = 1'b0;

        // Reset during RUN cycle 5 of run 1.
        begin
            exp_t e;
            lat_q.push_back(3);
            lat_q.push_back(50);
            lat_q.push_back(4);
            e.idx = 0; e.cyc = 3;  sb.push_back(e);
            e.idx = 1; e.cyc = 50; sb.push_back(e);
            e.idx = 2; e.cyc = 4;  sb.push_back(e);
            pulse_start();
            wait_run(1);
            repeat (4) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("rst_busy", busy, 0);
            check("rst_run_idx", run_idx, 0);
            check("rst_cycles", cycles, 0);
            check("rst_result_valid", result_valid, 0);
            check("rst_core_reset", core_reset, 1);
            check("rst_all_done", all_done, 0);
            sb.delete();
            lat_q.delete();
            repeat (8) @(negedge clk);
            check("rst_still_idle", busy, 0);
            run_seq(7, 8, 9, 7, 8, 9, 1'b0);
        end

`ifdef RUN_SEQUENCER_TIMEOUT_EN
        // Core never raises done: abort after TMO RUN cycles, cycles untouched.
        lat_q.push_back(100000);
        run_cyc = 0;
        pulse_start();
        wait_end();
        check("tmo_timed_out", timed_out, 1);
        check("tmo_run_cycles", run_cyc, TMO);
        check("tmo_core_reset", core_reset, 1);
        check("tmo_busy", busy, 0);
        check("tmo_all_done", all_done, 0);
        check("tmo_cycles_kept", cycles, 9);
        lat_q.delete();
        // done on the TMO-th RUN cycle wins over the timeout.
        run_seq(TMO - 1, 3, 4, TMO - 1, 3, 4, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
